// File: rtl/link_pkg.sv
// link_pkg: shared constants, types and word-assembly helper for the 8-bit CPU link.
// Used by the memory-side target and by any master-side model.
//   Phase constants : link phase numbers within an 18-cycle frame
//   link_word_t     : 64-bit link word
//   link_assemble   : rebuild a word from 8 lane bytes (byte 0 at [7:0])
package link_pkg;

   localparam int unsigned LINK_PHASES = 18;
   localparam int unsigned PH_W        = 5;

   typedef logic [63:0]     link_word_t;
   typedef logic [PH_W-1:0] link_phase_t;

   localparam link_phase_t PH_ADDR_FIRST = 5'd1;
   localparam link_phase_t PH_ADDR_LAST  = 5'd8;
   localparam link_phase_t PH_RW         = 5'd9;
   localparam link_phase_t PH_RD_FIRST   = 5'd10;
   localparam link_phase_t PH_LAST       = 5'd17;

   // Lane byte 7 carries word bits [62:55], so only 7 bits of lane byte 6 are
   // significant and bit 63 is always zero.
   function automatic link_word_t link_assemble(input link_word_t lanes);
      return {1'b0, lanes[63:56], lanes[54:48], lanes[47:0]};
   endfunction

endpackage

// File: rtl/link_phase_ctr.sv
// link_phase_ctr: free-running link phase counter (0..17, wraps) with frame_done.
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   phase      out  current phase
//   frame_done out  high in phase 0 once a phase-17 edge has occurred since reset
module link_phase_ctr
   import link_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output link_phase_t phase,
   output logic        frame_done
);

   link_phase_t ph_q, ph_d;
   logic        wrapped_q, wrapped_d;

   always_comb begin
      ph_d      = ph_q + 5'd1;
      wrapped_d = wrapped_q;
      if (ph_q == PH_LAST) begin
         ph_d      = '0;
         wrapped_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q      <= '0;
         wrapped_q <= 1'b0;
      end else begin
         ph_q      <= ph_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign phase      = ph_q;
   // Phase 0 after reset is not the end of a frame, hence the wrapped flag.
   assign frame_done = wrapped_q && (ph_q == '0);

endmodule

// File: rtl/link_mem_target.sv
// link_mem_target: memory-side endpoint of the 8-bit CPU link.
//   clk, rst      clock, synchronous active-high reset
//   link_addr     address lane (phases 1-8), rw flag bit 0 (phase 9, 1 = write)
//   link_din      write-data lane (phases 1-8)
//   link_dout     read-data lane, MSB byte first (phases 10-17)
//   link_oe       high while link_dout is driven
//   phase         current link phase 0..17
//   frame_done    pulse in phase 0 following a completed frame
//   dbg_addr      debug word index
//   dbg_rdata     combinational mem[dbg_addr]
//   err_cnt       saturating count of out-of-range accesses
module link_mem_target
   import link_pkg::*;
#(
   parameter int unsigned AW   = 4,
   parameter int unsigned ERRW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      link_addr,
   input  logic [7:0]      link_din,
   output logic [7:0]      link_dout,
   output logic            link_oe,
   output logic [4:0]      phase,
   output logic            frame_done,
   input  logic [AW-1:0]   dbg_addr,
   output logic [63:0]     dbg_rdata,
   output logic [ERRW-1:0] err_cnt
);

   link_phase_t     ph;
   link_word_t      alanes_q, dlanes_q, rword_q;
   logic            we_q;
   logic [ERRW-1:0] err_q;
   link_word_t      mem [2**AW];

   link_word_t      a_word, w_word;
   logic [AW-1:0]   idx;
   logic            oor, cap_en, rw_edge, do_write;
   logic [2:0]      lane_k, byte_sel;
   logic            unused_abits;

   link_phase_ctr u_phase_ctr (
      .clk        (clk),
      .rst        (rst),
      .phase      (ph),
      .frame_done (frame_done)
   );

   assign a_word       = link_assemble(alanes_q);
   assign w_word       = link_assemble(dlanes_q);
   assign idx          = a_word[AW+2:3];
   assign oor          = |a_word[62:AW+3];
   assign unused_abits = ^{a_word[63], a_word[2:0], w_word[63]};

   assign cap_en   = (ph >= PH_ADDR_FIRST) && (ph <= PH_ADDR_LAST);
   assign lane_k   = 3'(ph - PH_ADDR_FIRST);
   assign rw_edge  = (ph == PH_RW);
   assign do_write = rw_edge && link_addr[0] && !oor;

   always_ff @(posedge clk) begin
      if (rst) begin
         alanes_q <= '0;
         dlanes_q <= '0;
         rword_q  <= '0;
         we_q     <= 1'b0;
         err_q    <= '0;
      end else begin
         if (cap_en) begin
            alanes_q[{lane_k, 3'b000} +: 8] <= link_addr;
            dlanes_q[{lane_k, 3'b000} +: 8] <= link_din;
         end
         if (rw_edge) begin
            we_q <= link_addr[0];
            if (oor) begin
               rword_q <= '0;
               if (err_q != '1) err_q <= err_q + ERRW'(1);
            end else if (link_addr[0]) begin
               rword_q <= w_word;
            end else begin
               rword_q <= mem[idx];
            end
         end
      end
   end

   // Memory contents survive reset; a reset at the phase-9 edge cancels the write.
   always_ff @(posedge clk) begin
      if (!rst && do_write) mem[idx] <= w_word;
   end

   always_comb begin
      link_oe   = 1'b0;
      link_dout = '0;
      byte_sel  = 3'(PH_LAST - ph);
      if ((ph >= PH_RD_FIRST) && (ph <= PH_LAST) && !we_q) begin
         link_oe   = 1'b1;
         link_dout = rword_q[{byte_sel, 3'b000} +: 8];
      end
   end

   assign phase     = ph;
   assign dbg_rdata = mem[dbg_addr];
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_link_mem_target.sv
// tb_link_mem_target: scoreboard bench for link_mem_target acting as the link master.
module tb_link_mem_target;

   localparam int unsigned AW   = 4;
   localparam int unsigned ERRW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      link_addr, link_din, link_dout;
   logic            link_oe, frame_done;
   logic [4:0]      phase;
   logic [AW-1:0]   dbg_addr;
   logic [63:0]     dbg_rdata;
   logic [ERRW-1:0] err_cnt;

   always #5 clk = ~clk;

   link_mem_target #(.AW(AW), .ERRW(ERRW)) dut (
      .clk        (clk),
      .rst        (rst),
      .link_addr  (link_addr),
      .link_din   (link_din),
      .link_dout  (link_dout),
      .link_oe    (link_oe),
      .phase      (phase),
      .frame_done (frame_done),
      .dbg_addr   (dbg_addr),
      .dbg_rdata  (dbg_rdata),
      .err_cnt    (err_cnt)
   );

   int              errors = 0;
   int              checks = 0;
   logic [63:0]     model [16];
   logic [ERRW-1:0] exp_err;
   bit              seen17;
   logic [7:0]      rd_q [$];

   // Master-side serialisation: lane byte 7 = v[62:55], lane byte 6 = {0, v[54:48]}.
   function automatic logic [63:0] ser(input logic [63:0] v);
      logic [63:0] l;
      l          = v;
      l[63:56]   = v[62:55];
      l[55]      = 1'b0;
      return l;
   endfunction

   task automatic apply_reset();
      rst       = 1'b1;
      link_addr = '0;
      link_din  = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      seen17  = 1'b0;
      exp_err = '0;
      rd_q.delete();
   endtask

   // Runs one frame from phase 0. la/ld are raw lanes; ea is the intended address and
   // wd the word expected to be stored on a write.
   task automatic do_frame(input logic [63:0] la, input logic [63:0] ld, input logic rw,
                           input logic [63:0] ea, input logic [63:0] wd);
      bit         oor;
      logic [3:0] idx;
      logic [7:0] eb;
      bit         efd;
      oor = (ea[62:7] != '0);
      idx = ea[6:3];
      for (int p = 0; p < 18; p++) begin
         link_addr = '0;
         link_din  = '0;
         if (p >= 1 && p <= 8) begin
            link_addr = la[8*(p-1) +: 8];
            link_din  = ld[8*(p-1) +: 8];
         end
         if (p == 9) link_addr = {7'd0, rw};
         if (p == 10 && rw && !oor) dbg_addr = idx;
         @(negedge clk);
         checks++;
         if (phase !== 5'(p)) begin
            errors++;
            $display("FAIL phase: got %0d want %0d", phase, p);
         end
         efd = (p == 0) && seen17;
         checks++;
         if (frame_done !== efd) begin
            errors++;
            $display("FAIL frame_done ph%0d: got %b want %b", p, frame_done, efd);
         end
         if (p >= 10 && !rw) begin
            eb = rd_q.pop_front();
            checks++;
            if (link_oe !== 1'b1 || link_dout !== eb) begin
               errors++;
               $display("FAIL read_lane ph%0d: got oe=%b dout=%h want oe=1 dout=%h",
                        p, link_oe, link_dout, eb);
            end
         end else begin
            checks++;
            if (link_oe !== 1'b0 || link_dout !== 8'h00) begin
               errors++;
               $display("FAIL idle_lane ph%0d: got oe=%b dout=%h want oe=0 dout=00",
                        p, link_oe, link_dout);
            end
         end
         if (p == 10 && rw && !oor) begin
            checks++;
            if (dbg_rdata !== model[idx]) begin
               errors++;
               $display("FAIL dbg_after_write: got %h want %h", dbg_rdata, model[idx]);
            end
         end
         if (p == 9) begin
            if (oor) begin
               if (exp_err != '1) exp_err++;
               if (!rw) for (int b = 0; b < 8; b++) rd_q.push_back(8'h00);
            end else if (rw) begin
               model[idx] = wd;
            end else begin
               for (int b = 7; b >= 0; b--) rd_q.push_back(model[idx][8*b +: 8]);
            end
         end
         @(posedge clk);
         #1;
         if (p == 17) seen17 = 1'b1;
      end
      checks++;
      if (err_cnt !== exp_err) begin
         errors++;
         $display("FAIL err_cnt: got %h want %h", err_cnt, exp_err);
      end
   endtask

   task automatic check_dbg(input logic [3:0] i, input logic [63:0] want, input string nm);
      dbg_addr = i;
      #1;
      checks++;
      if (dbg_rdata !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, dbg_rdata, want);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (phase !== 5'd0 || frame_done !== 1'b0 || link_oe !== 1'b0 || link_dout !== 8'h00 ||
          err_cnt !== '0) begin
         errors++;
         $display("FAIL reset_vals: got ph=%0d fd=%b oe=%b dout=%h err=%h want 0 0 0 00 00",
                  phase, frame_done, link_oe, link_dout, err_cnt);
      end
      // Idle frame: zero lanes with the write flag set, so the lane is never driven.
      do_frame(64'd0, 64'd0, 1'b1, 64'd0, 64'd0);
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL frame_done_wrap: got %b want 1", frame_done);
      end
   endtask

   task automatic test_write();
      do_frame(ser(64'h10), ser(64'h0123456789ABCDEF), 1'b1, 64'h10, 64'h0123456789ABCDEF);
      check_dbg(4'd2, 64'h0123456789ABCDEF, "dbg_write");
   endtask

   task automatic test_read();
      do_frame(ser(64'h10), 64'd0, 1'b0, 64'h10, 64'd0);
   endtask

   task automatic test_ones();
      do_frame(ser(64'h18), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h18, 64'h7FFF_FFFF_FFFF_FFFF);
      check_dbg(4'd3, 64'h7FFF_FFFF_FFFF_FFFF, "dbg_ones");
      do_frame(ser(64'h18), 64'd0, 1'b0, 64'h18, 64'd0);
   endtask

   task automatic test_oor();
      do_frame(ser(64'h08), ser(64'h1111_2222_3333_4444), 1'b1, 64'h08, 64'h1111_2222_3333_4444);
      do_frame(ser(64'h80), 64'd0, 1'b0, 64'h80, 64'd0);
      checks++;
      if (err_cnt !== 8'h01) begin
         errors++;
         $display("FAIL err_first: got %h want 01", err_cnt);
      end
      check_dbg(4'd0, 64'd0, "oor_read_no_change");
      // Out-of-range write aliasing index 1 must leave it alone.
      do_frame(ser(64'h88), ser(64'hDEAD_BEEF_0000_0001), 1'b1, 64'h88, 64'd0);
      check_dbg(4'd1, 64'h1111_2222_3333_4444, "oor_write_no_change");
      for (int n = 0; n < 298; n++) do_frame(ser(64'h80), 64'd0, 1'b0, 64'h80, 64'd0);
      checks++;
      if (err_cnt !== 8'hFF) begin
         errors++;
         $display("FAIL err_saturate: got %h want ff", err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] la, ld;
      la = ser(64'h18);
      ld = ser(64'h0BAD_0BAD_0BAD_0BAD);
      for (int p = 0; p < 6; p++) begin
         link_addr = '0;
         link_din  = '0;
         if (p >= 1) begin
            link_addr = la[8*(p-1) +: 8];
            link_din  = ld[8*(p-1) +: 8];
         end
         if (p == 5) rst = 1'b1;
         @(posedge clk);
         #1;
      end
      rst     = 1'b0;
      seen17  = 1'b0;
      exp_err = '0;
      checks++;
      if (phase !== 5'd0 || frame_done !== 1'b0 || link_oe !== 1'b0 || err_cnt !== '0) begin
         errors++;
         $display("FAIL mid_reset: got ph=%0d fd=%b oe=%b err=%h want 0 0 0 00",
                  phase, frame_done, link_oe, err_cnt);
      end
      check_dbg(4'd3, 64'h7FFF_FFFF_FFFF_FFFF, "mid_reset_no_write");
      check_dbg(4'd2, 64'h0123456789ABCDEF, "mem_retained");
      do_frame(ser(64'h18), ser(64'h0000_5555_AAAA_1234), 1'b1, 64'h18, 64'h0000_5555_AAAA_1234);
      do_frame(ser(64'h18), 64'd0, 1'b0, 64'h18, 64'd0);
   endtask

   task automatic test_back_to_back();
      do_frame(ser(64'h28), ser(64'h7654_3210_FEDC_BA98), 1'b1, 64'h28, 64'h7654_3210_FEDC_BA98);
      do_frame(ser(64'h28), 64'd0, 1'b0, 64'h28, 64'd0);
      do_frame(ser(64'h30), ser(64'h00A5_5A00_C3C3_3C3C), 1'b1, 64'h30, 64'h00A5_5A00_C3C3_3C3C);
      do_frame(ser(64'h28), 64'd0, 1'b0, 64'h28, 64'd0);
      do_frame(ser(64'h30), 64'd0, 1'b0, 64'h30, 64'd0);
      checks++;
      if (rd_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", rd_q.size());
      end
   endtask

   initial begin
      rst       = 1'b1;
      link_addr = '0;
      link_din  = '0;
      dbg_addr  = '0;
      exp_err   = '0;
      seen17    = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_ones();
      test_oor();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
